// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first and repeats it
// a programmed number of times, with a one-cycle idle gap between copies.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [REP_W-1:0] i_repeat,
    input  logic             i_abort,
    output logic             o_sout,
    output logic             o_frame,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StGap   = 2'b10,
        StFin   = 2'b11
    } state_e;

    state_e           r_state, w_state;
    logic [WIDTH-1:0] r_hold, w_hold;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [CntW-1:0]  r_bitcnt, w_bitcnt;
    logic [REP_W-1:0] r_rep, w_rep;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_hold   <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_rep    <= '0;
        end else begin
            r_state  <= w_state;
            r_hold   <= w_hold;
            r_shift  <= w_shift;
            r_bitcnt <= w_bitcnt;
            r_rep    <= w_rep;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_hold   = r_hold;
        w_shift  = r_shift;
        w_bitcnt = r_bitcnt;
        w_rep    = r_rep;
        if (i_abort) begin
            // Abort wins over everything, including a simultaneous LOAD in IDLE.
            w_state  = StIdle;
            w_shift  = '0;
            w_bitcnt = '0;
            w_rep    = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_load) begin
                        w_hold   = i_data;
                        w_shift  = i_data;
                        w_rep    = i_repeat;
                        w_bitcnt = LastBit;
                        w_state  = StShift;
                    end
                end
                StShift: begin
                    w_shift  = {r_shift[WIDTH-2:0], 1'b0};
                    w_bitcnt = r_bitcnt - 1'b1;
                    if (r_bitcnt == '0) begin
                        if (r_rep == '0) begin
                            w_state = StFin;
                        end else begin
                            w_rep   = r_rep - 1'b1;
                            w_state = StGap;
                        end
                    end
                end
                StGap: begin
                    w_shift  = r_hold;
                    w_bitcnt = LastBit;
                    w_state  = StShift;
                end
                StFin: begin
                    w_state = StIdle;
                end
                default: begin
                    w_state = StIdle;
                end
            endcase
        end
    end

    assign o_sout  = (r_state == StShift) & r_shift[WIDTH-1];
    assign o_frame = (r_state == StShift);
    assign o_busy  = (r_state != StIdle);
    assign o_done  = (r_state == StFin);

endmodule
